// File: rtl/chip_invaders_pkg.sv
// rtl/chip_invaders_pkg.sv - shared screen/ship constants and shot FSM state type
package chip_invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SHIP_Y   = 440;
  localparam int SHIP_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } shot_state_t;

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - single-cycle rising-edge detector on an already-synchronous level
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/player_shot.sv
// rtl/player_shot.sv - player laser: launch on fire, per-frame climb, retire on hit/top, cooldown
module player_shot
  import chip_invaders_pkg::*;
#(
  parameter int SHOT_H          = 4,
  parameter int SHOT_SPEED      = 8,
  parameter int TOP_LIMIT       = 16,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] ship_x_pos,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       shot_on,
  output logic       shot_active,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic       shot_fired
);

  localparam logic [9:0] LAUNCH_Y = 10'(SHIP_Y - SHOT_H);
  localparam logic [9:0] RETIRE_Y = 10'(TOP_LIMIT + SHOT_SPEED);
  localparam logic [9:0] SPAWN_DX = 10'(SHIP_W / 2);
  localparam logic [9:0] STEP_Y   = 10'(SHOT_SPEED);
  localparam logic [7:0] CD_INIT  = 8'(COOLDOWN_FRAMES - 1);

  logic tick, fire_rise;

  rise_edge u_vsync_edge (.clk(clk), .rst_n(rst_n), .sig(v_sync), .rise(tick));
  rise_edge u_fire_edge  (.clk(clk), .rst_n(rst_n), .sig(fire),   .rise(fire_rise));

  shot_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  cd_q, cd_d;
  logic        fire_req_q, fire_req_d;
  logic        hit_lat_q, hit_lat_d;
  logic        fired_q, fired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cd_q       <= '0;
      fire_req_q <= 1'b0;
      hit_lat_q  <= 1'b0;
      fired_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cd_q       <= cd_d;
      fire_req_q <= fire_req_d;
      hit_lat_q  <= hit_lat_d;
      fired_q    <= fired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cd_d      = cd_q;
    fired_d   = 1'b0;
    hit_lat_d = hit_lat_q;
    // Presses outside IDLE are dropped; a latched press lives only until the next tick.
    fire_req_d = tick ? 1'b0 : (fire_req_q | (fire_rise & (state_q == ST_IDLE)));

    unique case (state_q)
      ST_IDLE: begin
        if (tick && (fire_req_q || fire_rise)) begin
          state_d = ST_FLYING;
          x_d     = ship_x_pos + SPAWN_DX;
          y_d     = LAUNCH_Y;
          fired_d = 1'b1;
        end
      end
      ST_FLYING: begin
        if (hit) hit_lat_d = 1'b1;
        if (tick) begin
          if (hit_lat_q || hit || (y_q < RETIRE_Y)) begin
            state_d = ST_COOLDOWN;
            cd_d    = CD_INIT;
          end else begin
            y_d = y_q - STEP_Y;
          end
        end
      end
      ST_COOLDOWN: begin
        if (tick) begin
          if (cd_q == 8'd0) state_d = ST_IDLE;
          else              cd_d    = cd_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick || (state_d != ST_FLYING)) hit_lat_d = 1'b0;
  end

  assign shot_active = (state_q == ST_FLYING);
  assign shot_x      = x_q;
  assign shot_y      = y_q;
  assign shot_fired  = fired_q;
  assign shot_on     = shot_active && (pix_x == x_q) && (pix_y >= y_q) &&
                       ({1'b0, pix_y} < ({1'b0, y_q} + 11'(SHOT_H)));

endmodule
